pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 2, giving the number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, the reset, synchronous and active-low.
REQ-005 The block SHALL have port x, input, WIDTH bits, operand A.
REQ-006 The block SHALL have port y, input, WIDTH bits, operand B.
REQ-007 The block SHALL have port cin, input, 1 bit, carry-in (borrow-in when sub=1).
REQ-008 The block SHALL have port sub, input, 1 bit, mode select: 0 = add, 1 = subtract.
REQ-009 The block SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit), forming the input handshake.
REQ-010 The block SHALL have port sum, output, WIDTH bits, the result.
REQ-011 The block SHALL have port cout, output, 1 bit, carry-out (0 = borrow when sub=1).
REQ-012 The block SHALL have port ovf, output, 1 bit, the signed overflow flag.
REQ-013 The block SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit), forming the output handshake.

Function
REQ-014 The block SHALL accept a transaction on a cycle where in_valid=1 and in_ready=1.
REQ-015 Add mode SHALL compute {cout,sum} = x + y + cin.
REQ-016 Subtract mode SHALL compute {cout,sum} = x + ~y + ~cin, i.e. x - y - cin, with cout=1 meaning no borrow.
REQ-017 Operands SHALL be split into STAGES chunks of WIDTH/STAGES bits; stage k SHALL add chunk k using the registered carry from stage k-1.
REQ-018 Upper operand chunks SHALL be delayed and completed lower sum chunks SHALL be carried forward, so that chunks stay aligned with their transaction.
REQ-019 A transaction accepted at cycle t SHALL appear on the outputs with out_valid=1 at cycle t+STAGES when there is no stall.
REQ-020 Each stage SHALL hold a valid bit; the global advance enable SHALL be en = !out_valid || out_ready.
REQ-021 in_ready SHALL equal en (combinational); every stage register SHALL update only when en=1.
REQ-022 Bubbles SHALL propagate as invalid stages, and a bubble SHALL never produce out_valid=1.
REQ-023 sum, cout and ovf SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 Sustained throughput SHALL be one transaction per cycle when out_ready=1 continuously.
REQ-025 Results SHALL leave the block in acceptance order; no transaction SHALL be dropped or duplicated.
REQ-026 When sub changes between back-to-back transactions, each transaction SHALL use its own sub and cin values.
REQ-027 At the wrap-around operand x=all-ones, y=0, cin=1, add mode SHALL produce sum=0 and cout=1.

Reset
REQ-028 When rst_n=0 at a clock edge, all stage valid bits, out_valid, sum, cout and ovf SHALL be 0 at the next cycle.
REQ-029 A reset mid-operation SHALL discard in-flight transactions; none SHALL emerge after reset.
REQ-030 in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-031 With OVERFLOW_FLAG_EN defined, ovf SHALL be 1 when the operand signs (after the subtract inversion) are equal and differ from the sign of sum, registered alongside the final stage.
REQ-032 Without OVERFLOW_FLAG_EN, ovf SHALL be tied to 0 and no overflow logic SHALL be generated.

Structure
REQ-033 Package adder_pkg SHALL hold DEFAULT_WIDTH=8 and DEFAULT_STAGES=2.
REQ-034 Sub-module adder_stage SHALL implement one chunk ripple add (chunk, carry in -> chunk sum, carry out), instantiated STAGES times via generate.

Verification (WIDTH=8, STAGES=2)
REQ-035 Inputs x=0x0F, y=0x01, cin=0, sub=0 SHALL produce sum=0x10, cout=0 two cycles later (carry crosses the chunk boundary).
REQ-036 Inputs x=0xFF, y=0x01, cin=1, sub=0 SHALL produce sum=0x01, cout=1.
REQ-037 Inputs x=0x05, y=0x07, cin=0, sub=1 SHALL produce sum=0xFE, cout=0, ovf=0.
REQ-038 Inputs x=0x7F, y=0x01, cin=0, sub=0 SHALL produce sum=0x80 with ovf=1 when OVERFLOW_FLAG_EN is defined and ovf=0 when it is not.
REQ-039 Four back-to-back transactions with out_ready held low for 3 cycles SHALL give in_ready=0 during the stall, outputs held stable, and all 4 results in order with no loss.
REQ-040 Asserting rst_n=0 for one cycle with 2 transactions in flight SHALL give out_valid=0 the next cycle, and no stale result SHALL appear afterwards.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared defaults and helpers for the pipelined adder slice.
package adder_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_STAGES = 2;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One chunk of the ripple add: chunk operands plus carry in give chunk sum plus carry out.
module adder_stage #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/pipelined_adder.sv
// Chunked add/subtract pipeline with a valid/ready handshake on both sides.
// Define OVERFLOW_FLAG_EN to build the registered signed-overflow flag; otherwise ovf is tied to 0.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    logic en;

    // The whole pipe advances together; it only freezes when a finished result is waiting.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : gen_stage
        // a_in/b_in hold only the chunks not yet consumed; s_q holds the finished low chunks.
        localparam int IN_W = WIDTH - k * CHUNK;
        localparam int LO_W = k * CHUNK;

        logic [IN_W-1:0]       a_in;
        logic [IN_W-1:0]       b_in;
        logic                  c_in;
        logic                  v_in;
        logic [CHUNK-1:0]      chunk_s;
        logic                  chunk_c;
        logic [LO_W+CHUNK-1:0] s_nx;
        logic [LO_W+CHUNK-1:0] s_q;
        logic                  c_q;
        logic                  v_q;

        if (k == 0) begin : g_src
            // Subtract folds into an add of the inverted operand and inverted borrow.
            assign a_in = x;
            assign b_in = sub ? ~y : y;
            assign c_in = sub ? ~cin : cin;
            assign v_in = in_valid;
            assign s_nx = chunk_s;
        end else begin : g_src
            assign a_in = gen_stage[k-1].g_fwd.a_q;
            assign b_in = gen_stage[k-1].g_fwd.b_q;
            assign c_in = gen_stage[k-1].c_q;
            assign v_in = gen_stage[k-1].v_q;
            assign s_nx = {chunk_s, gen_stage[k-1].s_q};
        end

        adder_stage #(
            .CHUNK(CHUNK)
        ) u_stage (
            .a   (a_in[CHUNK-1:0]),
            .b   (b_in[CHUNK-1:0]),
            .cin (c_in),
            .sum (chunk_s),
            .cout(chunk_c)
        );

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                c_q <= chunk_c;
                s_q <= s_nx;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IN_W-CHUNK-1:0] a_q;
            logic [IN_W-CHUNK-1:0] b_q;

            // Upper chunks ride along with their transaction until their stage comes up.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_in[IN_W-1:CHUNK];
                    b_q <= b_in[IN_W-1:CHUNK];
                end
            end
        end
    end

    assign sum       = gen_stage[STAGES-1].s_q;
    assign cout      = gen_stage[STAGES-1].c_q;
    assign out_valid = gen_stage[STAGES-1].v_q;

`ifdef OVERFLOW_FLAG_EN
    logic ovf_nx;
    logic ovf_q;

    // Overflow when both effective operand signs agree and the result sign disagrees.
    assign ovf_nx = (gen_stage[STAGES-1].a_in[CHUNK-1] == gen_stage[STAGES-1].b_in[CHUNK-1]) &&
                    (gen_stage[STAGES-1].chunk_s[CHUNK-1] != gen_stage[STAGES-1].a_in[CHUNK-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= ovf_nx;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed, table-driven bench for pipelined_adder (WIDTH=8, STAGES=2) with a handshake scoreboard.
module tb_pipelined_adder;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] x;
    logic [7:0] y;
    logic       cin;
    logic       sub;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;

    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   cyc       = 0;
    vec_t cur_vec;
    vec_t exp_q[$];
    vec_t vecs[11];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_sum;
    logic       prev_cout;
    logic       prev_ovf;

    pipelined_adder #(
        .WIDTH (8),
        .STAGES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .y        (y),
        .cin      (cin),
        .sub      (sub),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic exp_ovf(input logic o);
`ifdef OVERFLOW_FLAG_EN
        return o;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    endtask

    // Drives one transaction (called at posedge+2) and returns at posedge+2 after it is accepted.
    task automatic applyStimulus(input vec_t v);
        int waited;
        waited   = 0;
        cur_vec  = v;
        x        = v.x;
        y        = v.y;
        cin      = v.cin;
        sub      = v.sub;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready === 1'b1) break;
            waited++;
            if (waited > 20) begin
                checkOutput("accept_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(posedge clk);
            n++;
        end
        #2;
        checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: handshakes seen at the negedge commit on the following posedge.
    always @(negedge clk) begin
        vec_t e;
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                checkOutput("hold_stable", {21'd0, out_valid, sum, cout, ovf},
                            {21'd0, 1'b1, prev_sum, prev_cout, prev_ovf});
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sum", 32'(sum), 32'(e.sum));
                    checkOutput("cout", 32'(cout), 32'(e.cout));
                    checkOutput("ovf", 32'(ovf), 32'(exp_ovf(e.ovf)));
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) exp_q.push_back(cur_vec);
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_sum   = sum;
            prev_cout  = cout;
            prev_ovf   = ovf;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int c0;

        //            x      y      cin   sub   sum    cout  ovf
        vecs[0]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
        vecs[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4]  = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[6]  = '{8'h10, 8'h10, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[7]  = '{8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1};
        vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{8'hAA, 8'h55, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[10] = '{8'hC0, 8'hC0, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = 8'h00;
        y         = 8'h00;
        cin       = 1'b0;
        sub       = 1'b0;
        cur_vec   = vecs[0];

        // Reset state
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_sum", 32'(sum), 32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #2;

        // Latency of a lone transaction, followed by a bubble
        applyStimulus(vecs[0]);
        idle();
        @(negedge clk);
        checkOutput("latency_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        checkOutput("latency_cycle2_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        checkOutput("bubble_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #2;
        drain();

        // Back-to-back table at full throughput
        c0 = cyc;
        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);
        checkOutput("throughput_cycles", 32'(cyc - c0), 32'd11);
        idle();
        drain();

        // Four transactions with a three-cycle output stall
        out_ready = 1'b0;
        applyStimulus(vecs[3]);
        applyStimulus(vecs[2]);
        fork
            begin
                applyStimulus(vecs[5]);
                applyStimulus(vecs[1]);
                idle();
            end
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two transactions in flight
        out_ready = 1'b0;
        applyStimulus(vecs[7]);
        applyStimulus(vecs[9]);
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("no_stale_result", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #2;

        // Wrap-around after reset, then a sub toggle pair
        applyStimulus(vecs[4]);
        applyStimulus(vecs[8]);
        applyStimulus(vecs[6]);
        idle();
        drain();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
